imem_loader_ctrl: RTL and testbench

- Sequences the instruction ROM: fills it from the debug UART byte stream after reset or on command, then hands the memory port to the CPU fetch path.
- Sits between the UART receiver, the instruction memory (write-enabled variant) and the IF stage.
- While a load is in progress, the CPU is held stalled.
- Assembles bytes into words, writes them to sequential addresses, and stops on a halt word or when the memory is full.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_ctrl_packer.sv | 41 ++++
 rtl/imem_loader_ctrl.sv | 117 +++++++++++
 tb/tb_imem_loader_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State encoding, default halt marker and word geometry.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_HALT_WORD  = 32'hFFFF_FFFF;
  localparam int          DEF_WORD_WIDTH = 32;
  localparam int          BYTES_PER_WORD = DEF_WORD_WIDTH / 8;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/imem_loader_ctrl_packer.sv
// Byte-to-word assembler: MSB-first shift register plus byte counter.
// o_word_valid pulses combinationally on the strobe that completes a word.
module byte_word_packer
  import imem_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic [7:0]            i_byte,
  input  logic                  i_valid,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_word_valid
);

  localparam int BPW  = bytes_per_word(WORD_WIDTH);
  localparam int CNTW = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_WIDTH-1:0] shreg;
  logic [CNTW-1:0]       cnt;
  logic                  last;

  assign last         = (cnt == CNTW'(BPW - 1));
  assign o_word       = WORD_WIDTH'({shreg, i_byte});
  assign o_word_valid = i_valid && last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (i_clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (i_valid) begin
      shreg <= o_word;
      cnt   <= last ? '0 : cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/imem_loader_ctrl.sv
// Instruction memory loader: fills the ROM from the UART byte stream,
// then hands the memory address port to the CPU fetch path.
module imem_loader_ctrl
  import imem_loader_pkg::*;
#(
  parameter int MEM_SIZE    = 1024,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_LENGTH = 32,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD =
    WORD_WIDTH'(DEF_HALT_WORD),
  localparam int CW = $clog2(MEM_SIZE) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_start,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  input  logic [ADDR_LENGTH-1:0] i_fetch_addr,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic [WORD_WIDTH-1:0]  o_mem_wdata,
  output logic                   o_mem_we,
  output logic                   o_cpu_stall,
  output logic                   o_load_done,
  output logic                   o_overflow,
  output logic [CW-1:0]          o_word_count
);

  state_t                state, state_d;
  logic [CW-1:0]         ptr, ptr_d, cnt_d;
  logic                  ovf_d;
  logic                  we_d;
  logic [WORD_WIDTH-1:0] wdata_d;
  logic [WORD_WIDTH-1:0] word;
  logic                  word_valid;
  logic                  pk_valid;
  logic                  pk_clear;

  // Bytes arriving during the single WRITE cycle belong to the next word.
  assign pk_valid = i_rx_valid
                 && (state == LOAD || state == WRITE);

  byte_word_packer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (pk_clear),
    .i_byte      (i_rx_data),
    .i_valid     (pk_valid),
    .o_word      (word),
    .o_word_valid(word_valid)
  );

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    cnt_d    = o_word_count;
    ovf_d    = o_overflow;
    pk_clear = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (i_load_start) begin
          state_d  = LOAD;
          ptr_d    = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          pk_clear = 1'b1;
        end
      end
      LOAD: begin
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        cnt_d = o_word_count + CW'(1);
        if (o_mem_wdata == HALT_WORD) begin
          state_d = DONE;
        end else if (ptr == CW'(MEM_SIZE - 1)) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          ptr_d   = ptr + CW'(1);
          state_d = word_valid ? WRITE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    we_d    = (state_d == WRITE);
    wdata_d = we_d ? word : o_mem_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_wdata  <= '0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      o_word_count <= cnt_d;
      o_overflow   <= ovf_d;
      o_mem_we     <= we_d;
      o_mem_wdata  <= wdata_d;
    end
  end

  assign o_load_done = (state == DONE);
  assign o_cpu_stall = (state != DONE);

  always_comb begin
    o_mem_addr = ADDR_LENGTH'(ptr);
    if (state == DONE) o_mem_addr = i_fetch_addr;
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboard bench for imem_loader_ctrl with a 4-word memory.
// Expected writes are queued by stimulus and checked by a monitor.
module tb_imem_loader_ctrl;

  localparam int MS = 4;
  localparam int CW = $clog2(MS) + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [31:0]   fetch_addr;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          cpu_stall;
  logic          load_done;
  logic          overflow;
  logic [CW-1:0] word_count;

  wr_t exp_q[$];
  int  n_cmp;
  int  n_bad;

  imem_loader_ctrl #(
    .MEM_SIZE   (MS),
    .WORD_WIDTH (32),
    .ADDR_LENGTH(32),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_load_start(load_start),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_fetch_addr(fetch_addr),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .o_cpu_stall (cpu_stall),
    .o_load_done (load_done),
    .o_overflow  (overflow),
    .o_word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got @%0d=%h, required none",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr != e.addr || mem_wdata != e.data) begin
          n_bad++;
          $display("FAIL write: got @%0d=%h, required @%0d=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w,
                           input bit          exp_wr,
                           input int          addr,
                           input int          gap);
    logic [31:0] t;
    wr_t e;
    t = w;
    if (exp_wr) begin
      e.addr = addr;
      e.data = w;
      exp_q.push_back(e);
    end
    send_byte(t[31:24], 0);
    send_byte(t[23:16], 0);
    send_byte(t[15:8], 0);
    send_byte(t[7:0], gap);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!load_done && k < 20) begin
      tick();
      k++;
    end
    chk(name, {31'd0, load_done}, 32'd1);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    fetch_addr = 32'd0;
    #1;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Program load ending on halt word, with latency check
    pulse_start();
    send_word(32'h0000_0013, 1, 0, 1);
    send_word(32'h0010_0093, 1, 1, 1);
    send_word(32'hFFFF_FFFF, 1, 2, 0);
    chk("lat_we_n1", {31'd0, mem_we}, 32'd1);
    chk("lat_done_n1", {31'd0, load_done}, 32'd0);
    tick();
    chk("lat_done_n2", {31'd0, load_done}, 32'd1);
    chk("t1_stall", {31'd0, cpu_stall}, 32'd0);
    chk("t1_count", 32'(word_count), 32'd3);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);

    // Restart from DONE, then overflow a 4-word memory
    pulse_start();
    chk("rs_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rs_done", {31'd0, load_done}, 32'd0);
    chk("rs_count", 32'(word_count), 32'd0);
    send_word(32'h1111_1111, 1, 0, 1);
    send_word(32'h2222_2222, 1, 1, 1);
    send_word(32'h3333_3333, 1, 2, 1);
    send_word(32'h4444_4444, 1, 3, 1);
    wait_done("ovf_done");
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count", 32'(word_count), 32'd4);
    send_word(32'h5555_5555, 0, 0, 2);
    chk("ovf_count_hold", 32'(word_count), 32'd4);

    // Fetch pass-through in DONE, then restart resets pointer
    fetch_addr = 32'd7;
    #1;
    chk("fetch_addr", mem_addr, 32'd7);
    chk("fetch_we", {31'd0, mem_we}, 32'd0);
    pulse_start();
    chk("rs2_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rs2_done", {31'd0, load_done}, 32'd0);
    chk("rs2_ptr", mem_addr, 32'd0);
    chk("rs2_ovf", {31'd0, overflow}, 32'd0);

    // Asynchronous reset mid-word
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_stall", {31'd0, cpu_stall}, 32'd1);
    chk("mr_done", {31'd0, load_done}, 32'd0);
    chk("mr_we", {31'd0, mem_we}, 32'd0);
    chk("mr_wdata", mem_wdata, 32'd0);
    chk("mr_count", 32'(word_count), 32'd0);
    tick();
    rst_n = 1'b1;
    send_word(32'hBEEF_0001, 0, 0, 2);
    chk("mr_idle_count", 32'(word_count), 32'd0);
    chk("mr_idle_stall", {31'd0, cpu_stall}, 32'd1);

    // Start pulse mid-load is ignored
    pulse_start();
    send_word(32'hAABB_CCDD, 1, 0, 1);
    pulse_start();
    send_word(32'h0102_0304, 1, 1, 1);
    chk("nr_count", 32'(word_count), 32'd2);
    chk("nr_ptr", mem_addr, 32'd2);

    // Back-to-back bytes, including during WRITE
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_word(32'hCAFE_0001, 1, 0, 0);
    send_word(32'hCAFE_0002, 1, 1, 1);
    send_word(32'hFFFF_FFFF, 1, 2, 1);
    wait_done("b2b_done");
    chk("b2b_count", 32'(word_count), 32'd3);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
